// File: rtl/systolic_feeder_if.sv
// Host-side operand load/start bundle and array-edge lanes of the systolic feeder.
// repeat_req exists only when FEEDER_REPEAT_EN is defined.
interface systolic_feeder_if #(
    parameter int N = 2,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic            wr_en;
    logic            wr_sel;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [W-1:0]    wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [N*W-1:0]  a_out;
    logic [N*W-1:0]  b_out;
`ifdef FEEDER_REPEAT_EN
    logic            repeat_req;
`endif

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
`ifdef FEEDER_REPEAT_EN
        output repeat_req,
`endif
        input  busy, done, a_out, b_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
`ifdef FEEDER_REPEAT_EN
        input  repeat_req,
`endif
        output busy, done, a_out, b_out
    );
endinterface

// File: rtl/systolic_feeder.sv
// Streams skewed, zero-padded A rows / B columns into a systolic MAC array edge; lanes registered, first operand one cycle after start.
// No backpressure: writes/start honoured only in IDLE. FEEDER_REPEAT_EN adds back-to-back reruns via repeat_req.
module systolic_feeder #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int HOP   = 2,
    parameter int DRAIN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    systolic_feeder_if.slave bus
);
    localparam int SLEN = (N - 1) * HOP + N;
    localparam int CW   = $clog2(SLEN + DRAIN) + 1;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      t_q, t_d;
    logic [W-1:0]       a_mat_q [N][N];
    logic [W-1:0]       a_mat_d [N][N];
    logic [W-1:0]       b_mat_q [N][N];
    logic [W-1:0]       b_mat_d [N][N];
    logic [N*W-1:0]     a_out_q, a_out_d;
    logic [N*W-1:0]     b_out_q, b_out_d;
    logic signed [CW:0] diff;
    logic               rep_done;
    logic               idle;

    assign idle = (state_q == S_IDLE);

    // Write is forwarded so a start in the same cycle streams the new value.
    always_comb begin
        a_mat_d = a_mat_q;
        b_mat_d = b_mat_q;
        if (idle && bus.wr_en) begin
            if (bus.wr_sel == 1'b0) begin
                a_mat_d[bus.wr_row][bus.wr_col] = bus.wr_data;
            end else begin
                b_mat_d[bus.wr_row][bus.wr_col] = bus.wr_data;
            end
        end
    end

    // One counter spans STREAM (t < SLEN) and DRAIN (SLEN <= t < SLEN+DRAIN).
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        rep_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                end
            end
            S_STREAM: begin
                if (t_q == CW'(SLEN - 1)) begin
                    state_d = S_DRAIN;
                end
                t_d = t_q + 1'b1;
            end
            S_DRAIN: begin
                if (t_q == CW'(SLEN + DRAIN - 1)) begin
                    state_d = S_DONE;
                    t_d     = '0;
`ifdef FEEDER_REPEAT_EN
                    if (bus.repeat_req) begin
                        state_d  = S_STREAM;
                        rep_done = 1'b1;
                    end
`endif
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Lanes are computed from next-state so the registered outputs line up with t.
    always_comb begin
        a_out_d = '0;
        b_out_d = '0;
        diff    = '0;
        if (state_d == S_STREAM) begin
            for (int i = 0; i < N; i++) begin
                diff = $signed({1'b0, t_d}) - $signed((CW+1)'(i * HOP));
                if (diff >= 0 && diff < $signed((CW+1)'(N))) begin
                    a_out_d[i*W +: W] = a_mat_d[i][diff[IW-1:0]];
                    b_out_d[i*W +: W] = b_mat_d[diff[IW-1:0]][i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mat_q[r][c] <= '0;
                    b_mat_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            a_mat_q <= a_mat_d;
            b_mat_q <= b_mat_d;
        end
    end

    assign bus.busy  = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign bus.done  = (state_q == S_DONE) || rep_done;
    assign bus.a_out = a_out_q;
    assign bus.b_out = b_out_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: start-relative schedule model plus literal checks.
module tb_systolic_feeder;
    localparam int N     = 2;
    localparam int W     = 8;
    localparam int HOP   = 2;
    localparam int DRAIN = 8;
    localparam int SLEN  = (N - 1) * HOP + N;
    localparam int RUN   = SLEN + DRAIN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .W(W)) bus ();
    systolic_feeder #(.N(N), .W(W), .HOP(HOP), .DRAIN(DRAIN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    systolic_feeder_if #(.N(3), .W(8)) bus3 ();
    systolic_feeder #(.N(3), .W(8), .HOP(1), .DRAIN(8)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int run_start = -1;
    bit check_en  = 1'b0;
    logic [W-1:0] mA [N][N];
    logic [W-1:0] mB [N][N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Position of the current cycle relative to the cycle after start was accepted.
    function automatic int kk();
        return (run_start < 0) ? -1000 : (cyc - run_start - 1);
    endfunction

    function automatic bit model_idle();
        return (run_start < 0) || (kk() > RUN);
    endfunction

    function automatic logic [N*W-1:0] exp_a();
        logic [N*W-1:0] v;
        int k;
        int d;
        v = '0;
        k = kk();
        if (run_start >= 0 && k >= 0 && k < SLEN) begin
            for (int i = 0; i < N; i++) begin
                d = k - i * HOP;
                if (d >= 0 && d < N) v[i*W +: W] = mA[i][d];
            end
        end
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_b();
        logic [N*W-1:0] v;
        int k;
        int d;
        v = '0;
        k = kk();
        if (run_start >= 0 && k >= 0 && k < SLEN) begin
            for (int j = 0; j < N; j++) begin
                d = k - j * HOP;
                if (d >= 0 && d < N) v[j*W +: W] = mB[d][j];
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy();
        return (run_start >= 0) && (kk() >= 0) && (kk() < RUN);
    endfunction

    function automatic logic exp_done();
        logic v;
        v = (run_start >= 0) && (kk() == RUN);
`ifdef FEEDER_REPEAT_EN
        if (run_start >= 0 && kk() == RUN - 1 && bus.repeat_req) v = 1'b1;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mA[r][c] <= '0;
                    mB[r][c] <= '0;
                end
            end
            run_start <= -1;
        end else begin
`ifdef FEEDER_REPEAT_EN
            if (run_start >= 0 && kk() == RUN - 1 && bus.repeat_req) run_start <= cyc;
`endif
            if (model_idle()) begin
                if (bus.wr_en) begin
                    if (bus.wr_sel) mB[bus.wr_row][bus.wr_col] <= bus.wr_data;
                    else            mA[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end
                if (bus.start) run_start <= cyc;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_a_out", bus.a_out, exp_a());
            chk("cmp_b_out", bus.b_out, exp_b());
            chk("cmp_busy", bus.busy, exp_busy());
            chk("cmp_done", bus.done, exp_done());
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic r, input logic c, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_row = r; bus.wr_col = c; bus.wr_data = d;
        nxt();
        bus.wr_en = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
        bus3.wr_en = 1'b1; bus3.wr_sel = 1'b0; bus3.wr_row = r; bus3.wr_col = c; bus3.wr_data = d;
        nxt();
        bus3.wr_en = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        nxt();
        bus.start = 1'b0;
    endtask

    logic [7:0] lane2_tbl [7];

    initial begin
        rst = 1'b1;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 0; bus.start = 0;
        bus3.wr_en = 0; bus3.wr_sel = 0; bus3.wr_row = 0; bus3.wr_col = 0; bus3.wr_data = 0; bus3.start = 0;
`ifdef FEEDER_REPEAT_EN
        bus.repeat_req = 1'b0;
        bus3.repeat_req = 1'b0;
`endif
        lane2_tbl[0] = 8'h00; lane2_tbl[1] = 8'h00; lane2_tbl[2] = 8'h07; lane2_tbl[3] = 8'h08;
        lane2_tbl[4] = 8'h09; lane2_tbl[5] = 8'h00; lane2_tbl[6] = 8'h00;
        nxt(); nxt();
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_a_out", bus.a_out, 0);
        chk("rst_b_out", bus.b_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        // Basic skewed schedule, with a start+write attempt while busy.
        wr(0, 0, 0, 8'h11); wr(0, 0, 1, 8'h12); wr(0, 1, 0, 8'h21); wr(0, 1, 1, 8'h22);
        wr(1, 0, 0, 8'h31); wr(1, 0, 1, 8'h32); wr(1, 1, 0, 8'h41); wr(1, 1, 1, 8'h42);
        go();
        chk("t1_a_c1", bus.a_out, 16'h0011); chk("t1_b_c1", bus.b_out, 16'h0031);
        nxt();
        chk("t1_a_c2", bus.a_out, 16'h0012); chk("t1_b_c2", bus.b_out, 16'h0041);
        nxt();
        chk("t1_a_c3", bus.a_out, 16'h2100); chk("t1_b_c3", bus.b_out, 16'h3200);
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 8'hFF;
        nxt();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        chk("t1_a_c4", bus.a_out, 16'h2200); chk("t1_b_c4", bus.b_out, 16'h4200);
        chk("t1_busy_c4", bus.busy, 1);
        repeat (8) nxt();
        chk("t1_busy_c12", bus.busy, 1); chk("t1_done_c12", bus.done, 0);
        nxt();
        chk("t1_done_c13", bus.done, 1); chk("t1_busy_c13", bus.busy, 0);
        nxt();
        chk("t1_done_c14", bus.done, 0);

        // Busy-time write was dropped.
        go();
        chk("t2_lane0", bus.a_out[7:0], 8'h11);
        repeat (13) nxt();

        // Write and start in the same idle cycle.
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 1; bus.wr_col = 1; bus.wr_data = 8'h5A;
        bus.start = 1'b1;
        nxt();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        nxt(); nxt();
        chk("t3_lane1_c3", bus.a_out[15:8], 8'h21);
        nxt();
        chk("t3_lane1_c4", bus.a_out[15:8], 8'h5A);
        repeat (10) nxt();

        // Reset mid-stream aborts and clears storage.
        go();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("t4_busy", bus.busy, 0); chk("t4_done", bus.done, 0);
        chk("t4_a", bus.a_out, 0); chk("t4_b", bus.b_out, 0);
        nxt();
        chk("t4_done_after", bus.done, 0);
        go();
        for (int i = 0; i < SLEN; i++) begin
            chk("t4_zero_a", bus.a_out, 0);
            chk("t4_zero_b", bus.b_out, 0);
            nxt();
        end
        repeat (RUN - SLEN) nxt();
        chk("t4_done_rerun", bus.done, 1);
        nxt();

        // N=3, HOP=1 instance: row 2 appears at t=2..4, 13 busy cycles.
        wr3(2, 0, 8'h07); wr3(2, 1, 8'h08); wr3(2, 2, 8'h09);
        bus3.start = 1'b1;
        nxt();
        bus3.start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            chk("t5_lane2", bus3.a_out[23:16], lane2_tbl[t]);
            if (t == 4) chk("t5_busy_t4", bus3.busy, 1);
            nxt();
        end
        repeat (5) nxt();
        chk("t5_busy_t12", bus3.busy, 1); chk("t5_done_t12", bus3.done, 0);
        nxt();
        chk("t5_done_t13", bus3.done, 1); chk("t5_busy_t13", bus3.busy, 0);
        nxt();

`ifdef FEEDER_REPEAT_EN
        // Back-to-back rerun with no reload.
        wr(0, 0, 0, 8'h11); wr(1, 0, 0, 8'h31);
        go();
        repeat (10) nxt();
        bus.repeat_req = 1'b1;
        nxt();
        chk("t6_done", bus.done, 1); chk("t6_busy", bus.busy, 1);
        bus.repeat_req = 1'b0;
        nxt();
        chk("t6_a_restart", bus.a_out, 16'h0011); chk("t6_b_restart", bus.b_out, 16'h0031);
        chk("t6_busy_restart", bus.busy, 1);
        repeat (13) nxt();
`endif

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
